swipt_link_sequencer: RTL and testbench

- Startup/tracking controller for the SWIPT carrier loop.
- Sequences the carrier-frequency word into the SWIPT output generator.
- Holds the PLL in load mode while the link settles, then hands the PLL input over from the ADC comparator to the error loopback.
- Declares lock or fault from the PLL frequency estimate. Sits between the heartbeat detector, PLL and SWIPT output generator.

---
 rtl/swipt_pkg.sv | 20 ++
 rtl/swipt_lock_detect.sv | 75 +++++++
 rtl/swipt_link_sequencer.sv | 156 +++++++++++++++
 tb/tb_swipt_link_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT carrier-loop sequencer.
// Holds the state encoding, word widths, reset target and loop-gain codes.
package swipt_pkg;

    localparam int FREQ_W = 32;
    localparam int LG_W   = 5;

    localparam logic [FREQ_W-1:0] FREQ_DEFAULT = 32'h9C40;
    localparam logic [LG_W-1:0]   LG_ACQ       = 5'd7;
    localparam logic [LG_W-1:0]   LG_TRK       = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

endpackage

// File: rtl/swipt_lock_detect.sv
// Frequency-window compare with consecutive in-window / out-of-window counters.
// Emits one-cycle lock (while acquiring) and unlock (while tracking) pulses.
module swipt_lock_detect
    import swipt_pkg::*;
#(
    parameter int LOCK_TOL   = 'h64,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acq_en,
    input  logic              trk_en,
    input  logic [FREQ_W-1:0] target,
    input  logic [FREQ_W-1:0] pll_f,
    input  logic              pll_f_valid,
    output logic              lock_pulse,
    output logic              unlock_pulse,
    output logic              in_win_valid
);

    localparam int IN_W  = $clog2(LOCK_CNT + 1);
    localparam int OUT_W = $clog2(UNLOCK_CNT + 1);

    logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
    logic [FREQ_W:0]  diff;
    logic             in_window;
    logic             out_win_valid;

    always_comb begin
        // One extra bit so the distance never wraps.
        if (pll_f >= target) diff = {1'b0, pll_f} - {1'b0, target};
        else                 diff = {1'b0, target} - {1'b0, pll_f};
        in_window     = (diff <= (FREQ_W+1)'(LOCK_TOL));
        in_win_valid  = pll_f_valid && in_window;
        out_win_valid = pll_f_valid && !in_window;

        lock_pulse   = 1'b0;
        unlock_pulse = 1'b0;
        in_cnt_d     = '0;
        out_cnt_d    = '0;

        if (acq_en) begin
            in_cnt_d = in_cnt_q;
            if (in_win_valid) begin
                if (in_cnt_q == IN_W'(LOCK_CNT - 1)) lock_pulse = 1'b1;
                else                                 in_cnt_d   = in_cnt_q + IN_W'(1);
            end else if (out_win_valid) begin
                in_cnt_d = '0;
            end
        end

        if (trk_en) begin
            out_cnt_d = out_cnt_q;
            if (out_win_valid) begin
                if (out_cnt_q == OUT_W'(UNLOCK_CNT - 1)) unlock_pulse = 1'b1;
                else                                     out_cnt_d    = out_cnt_q + OUT_W'(1);
            end else if (in_win_valid) begin
                out_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: rtl/swipt_link_sequencer.sv
// Startup/tracking FSM for the SWIPT carrier loop: settle, acquire, lock, fault.
// Define SWIPT_GAIN_SCHED_EN to switch the loop gain to the tracking value while locked.
module swipt_link_sequencer
    import swipt_pkg::*;
#(
    parameter int SETTLE_CYC  = 1000,
    parameter int LOCK_TOL    = 'h64,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4,
    parameter int ACQ_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swipt_alive,
    input  logic [FREQ_W-1:0] pll_f,
    input  logic              pll_f_valid,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic              cfg_wr,
    output logic              load_freq,
    output logic              pll_sel,
    output logic [FREQ_W-1:0] freq,
    output logic [LG_W-1:0]   lgcoefficient,
    output logic              locked,
    output logic              fault,
    output logic [2:0]        state
);

    localparam int SW = $clog2(SETTLE_CYC);
    localparam int AW = $clog2(ACQ_TIMEOUT);

    state_e            state_q, state_d;
    logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [AW-1:0]     acq_cnt_q, acq_cnt_d;
    logic [FREQ_W-1:0] target_q, target_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [LG_W-1:0]   lg_q, lg_d;
    logic              load_freq_q, load_freq_d;
    logic              pll_sel_q, pll_sel_d;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;
    logic              lock_pulse, unlock_pulse, in_win_valid;

    swipt_lock_detect #(
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_detect (
        .clk          (clk),
        .rst          (rst),
        .acq_en       (state_q == ST_ACQUIRE),
        .trk_en       (state_q == ST_LOCKED),
        .target       (target_q),
        .pll_f        (pll_f),
        .pll_f_valid  (pll_f_valid),
        .lock_pulse   (lock_pulse),
        .unlock_pulse (unlock_pulse),
        .in_win_valid (in_win_valid)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        acq_cnt_d    = acq_cnt_q;
        target_d     = cfg_wr ? cfg_freq : target_q;
        freq_d       = freq_q;

        case (state_q)
            ST_IDLE: begin
                if (swipt_alive) begin
                    state_d      = ST_LOAD;
                    settle_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                settle_cnt_d = settle_cnt_q + SW'(1);
                if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
                    state_d   = ST_ACQUIRE;
                    acq_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                acq_cnt_d = acq_cnt_q + AW'(1);
                // Lock is checked first so it wins over a coincident timeout.
                if (lock_pulse)                               state_d = ST_LOCKED;
                else if (acq_cnt_q == AW'(ACQ_TIMEOUT - 1))   state_d = ST_FAULT;
            end
            ST_LOCKED: begin
                if (unlock_pulse) begin
                    state_d      = ST_LOAD;
                    settle_cnt_d = '0;
                end
            end
            ST_FAULT: begin
                if (cfg_wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cfg_wr && (state_q == ST_ACQUIRE || state_q == ST_LOCKED)) begin
            state_d      = ST_LOAD;
            settle_cnt_d = '0;
        end
        if (!swipt_alive && state_q != ST_IDLE) state_d = ST_IDLE;

        // Outputs are derived from the next state so every one is registered.
        if (state_d == ST_LOCKED) begin
            if (state_q != ST_LOCKED || in_win_valid) freq_d = pll_f;
        end else begin
            freq_d = target_d;
        end
        load_freq_d = !(state_d == ST_ACQUIRE || state_d == ST_LOCKED);
        pll_sel_d   = !load_freq_d;
        locked_d    = (state_d == ST_LOCKED);
        fault_d     = (state_d == ST_FAULT);
`ifdef SWIPT_GAIN_SCHED_EN
        lg_d        = (state_d == ST_LOCKED) ? LG_TRK : LG_ACQ;
`else
        lg_d        = LG_ACQ;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            acq_cnt_q    <= '0;
            target_q     <= FREQ_DEFAULT;
            freq_q       <= FREQ_DEFAULT;
            lg_q         <= LG_ACQ;
            load_freq_q  <= 1'b1;
            pll_sel_q    <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            acq_cnt_q    <= acq_cnt_d;
            target_q     <= target_d;
            freq_q       <= freq_d;
            lg_q         <= lg_d;
            load_freq_q  <= load_freq_d;
            pll_sel_q    <= pll_sel_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
        end
    end

    assign load_freq     = load_freq_q;
    assign pll_sel       = pll_sel_q;
    assign freq          = freq_q;
    assign lgcoefficient = lg_q;
    assign locked        = locked_q;
    assign fault         = fault_q;
    assign state         = state_q;

endmodule

// File: tb/tb_swipt_link_sequencer.sv
// Self-checking bench for swipt_link_sequencer: settle timing, lock/unlock,
// timeout fault, link drop, cfg writes and mid-run reset.
module tb_swipt_link_sequencer;

    localparam logic [4:0] LG_A = 5'd7;
`ifdef SWIPT_GAIN_SCHED_EN
    localparam logic [4:0] LG_L = 5'd10;
`else
    localparam logic [4:0] LG_L = 5'd7;
`endif

    logic        clk;
    logic        rst;
    logic        swipt_alive;
    logic [31:0] pll_f;
    logic        pll_f_valid;
    logic [31:0] cfg_freq;
    logic        cfg_wr;
    logic        load_freq;
    logic        pll_sel;
    logic [31:0] freq;
    logic [4:0]  lgcoefficient;
    logic        locked;
    logic        fault;
    logic [2:0]  state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    swipt_link_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .swipt_alive   (swipt_alive),
        .pll_f         (pll_f),
        .pll_f_valid   (pll_f_valid),
        .cfg_freq      (cfg_freq),
        .cfg_wr        (cfg_wr),
        .load_freq     (load_freq),
        .pll_sel       (pll_sel),
        .freq          (freq),
        .lgcoefficient (lgcoefficient),
        .locked        (locked),
        .fault         (fault),
        .state         (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change just after the falling edge, outputs are read there too.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_sample(input logic [31:0] f);
        pll_f       = f;
        pll_f_valid = 1'b1;
        tick();
        pll_f_valid = 1'b0;
    endtask

    task automatic send_cfg(input logic [31:0] f);
        cfg_freq = f;
        cfg_wr   = 1'b1;
        tick();
        cfg_wr   = 1'b0;
    endtask

    // Entered with the DUT already observed in LOAD.
    task automatic wait_settle();
        int n;
        n = 0;
        while (state == 3'd1 && load_freq === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        checks++; if (n != 1000) begin errors++; $display("FAIL settle_len: got %0d want 1000", n); end
        checks++; if (load_freq !== 1'b0) begin errors++; $display("FAIL settle_load_freq: got %b want 0", load_freq); end
        checks++; if (pll_sel !== 1'b1) begin errors++; $display("FAIL settle_pll_sel: got %b want 1", pll_sel); end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL settle_state: got %0d want 2", state); end
    endtask

    task automatic acquire_lock(input logic [31:0] f);
        for (int i = 0; i < 15; i++) send_sample(f);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", locked); end
        exp_q.push_back(f);
        send_sample(f);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_set: got %b want 1", locked); end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL lock_state: got %0d want 3", state); end
        exp = exp_q.pop_front();
        checks++; if (freq !== exp) begin errors++; $display("FAIL lock_freq: got %h want %h", freq, exp); end
        checks++; if (lgcoefficient !== LG_L) begin errors++; $display("FAIL lock_lg: got %0d want %0d", lgcoefficient, LG_L); end
    endtask

    task automatic test_reset();
        rst = 1'b1; swipt_alive = 1'b0; pll_f = '0; pll_f_valid = 1'b0; cfg_freq = '0; cfg_wr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (load_freq !== 1'b1) begin errors++; $display("FAIL rst_load_freq: got %b want 1", load_freq); end
        checks++; if (pll_sel !== 1'b0) begin errors++; $display("FAIL rst_pll_sel: got %b want 0", pll_sel); end
        checks++; if (freq !== 32'h9C40) begin errors++; $display("FAIL rst_freq: got %h want 9c40", freq); end
        checks++; if (lgcoefficient !== LG_A) begin errors++; $display("FAIL rst_lg: got %0d want 7", lgcoefficient); end
        checks++; if (locked !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b want 00", locked, fault); end
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", state); end
    endtask

    task automatic test_settle();
        swipt_alive = 1'b1;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL load_entry: got %0d want 1", state); end
        wait_settle();
    endtask

    task automatic test_lock();
        for (int i = 0; i < 15; i++) send_sample(32'h9C80);
        send_sample(32'h9D00);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_restart_a: got %b want 0", locked); end
        for (int i = 0; i < 15; i++) send_sample(32'h9C80);
        checks++; if (locked !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL lock_restart_b: got %b/%0d want 0/2", locked, state); end
        exp_q.push_back(32'h9C80);
        send_sample(32'h9C80);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_16: got %b want 1", locked); end
        exp = exp_q.pop_front();
        checks++; if (freq !== exp) begin errors++; $display("FAIL lock_16_freq: got %h want %h", freq, exp); end
        checks++; if (lgcoefficient !== LG_L) begin errors++; $display("FAIL lock_16_lg: got %0d want %0d", lgcoefficient, LG_L); end
        exp_q.push_back(32'h9C10);
        send_sample(32'h9C10);
        exp = exp_q.pop_front();
        checks++; if (freq !== exp) begin errors++; $display("FAIL track_freq: got %h want %h", freq, exp); end
    endtask

    task automatic test_unlock();
        for (int i = 0; i < 3; i++) send_sample(32'hA000);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL unlock_3bad: got %b want 1", locked); end
        exp_q.push_back(32'h9C40);
        send_sample(32'h9C40);
        exp = exp_q.pop_front();
        checks++; if (locked !== 1'b1 || freq !== exp) begin errors++; $display("FAIL unlock_good: got %b/%h want 1/%h", locked, freq, exp); end
        for (int i = 0; i < 3; i++) send_sample(32'hA000);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL unlock_restart: got %b want 1", locked); end
        send_sample(32'hA000);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL unlock_locked: got %b want 0", locked); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL unlock_state: got %0d want 1", state); end
        checks++; if (freq !== 32'h9C40) begin errors++; $display("FAIL unlock_freq: got %h want 9c40", freq); end
        checks++; if (load_freq !== 1'b1 || pll_sel !== 1'b0) begin errors++; $display("FAIL unlock_mux: got %b%b want 10", load_freq, pll_sel); end
        checks++; if (lgcoefficient !== LG_A) begin errors++; $display("FAIL unlock_lg: got %0d want 7", lgcoefficient); end
        wait_settle();
    endtask

    task automatic test_alive_drop();
        acquire_lock(32'h9C00);
        swipt_alive = 1'b0;
        pll_f       = 32'h9C40;
        pll_f_valid = 1'b1;
        tick();
        pll_f_valid = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL drop_state: got %0d want 0", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL drop_locked: got %b want 0", locked); end
        checks++; if (load_freq !== 1'b1 || pll_sel !== 1'b0) begin errors++; $display("FAIL drop_mux: got %b%b want 10", load_freq, pll_sel); end
        checks++; if (lgcoefficient !== LG_A) begin errors++; $display("FAIL drop_lg: got %0d want 7", lgcoefficient); end
        test_settle();
    endtask

    task automatic test_cfg_reacquire();
        acquire_lock(32'h9C40);
        send_cfg(32'h9D00);
        checks++; if (state !== 3'd1 || locked !== 1'b0) begin errors++; $display("FAIL cfg_reacq: got %0d/%b want 1/0", state, locked); end
        checks++; if (freq !== 32'h9D00) begin errors++; $display("FAIL cfg_reacq_freq: got %h want 9d00", freq); end
        wait_settle();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        send_sample(32'h0000_1000);
        n++;
        while (state == 3'd2 && fault === 1'b0 && n < 70000) begin
            n++;
            tick();
        end
        checks++; if (n != 65535) begin errors++; $display("FAIL timeout_len: got %0d want 65535", n); end
        checks++; if (fault !== 1'b1 || state !== 3'd4) begin errors++; $display("FAIL timeout_fault: got %b/%0d want 1/4", fault, state); end
        checks++; if (load_freq !== 1'b1 || pll_sel !== 1'b0) begin errors++; $display("FAIL timeout_mux: got %b%b want 10", load_freq, pll_sel); end
        tick(); tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", fault); end
        send_cfg(32'hC350);
        checks++; if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %0d/%b want 0/0", state, fault); end
        checks++; if (freq !== 32'hC350) begin errors++; $display("FAIL fault_cfg_freq: got %h want c350", freq); end
    endtask

    task automatic test_cfg_load_and_reset();
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL reload_state: got %0d want 1", state); end
        send_sample(32'h9C40);
        checks++; if (state !== 3'd1 || locked !== 1'b0) begin errors++; $display("FAIL load_ignores_valid: got %0d/%b want 1/0", state, locked); end
        send_cfg(32'hABCD);
        checks++; if (freq !== 32'hABCD || state !== 3'd1) begin errors++; $display("FAIL load_cfg: got %h/%0d want abcd/1", freq, state); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        swipt_alive = 1'b0;
        checks++; if (state !== 3'd0 || freq !== 32'h9C40) begin errors++; $display("FAIL midrst: got %0d/%h want 0/9c40", state, freq); end
        checks++; if (load_freq !== 1'b1 || pll_sel !== 1'b0) begin errors++; $display("FAIL midrst_mux: got %b%b want 10", load_freq, pll_sel); end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_lock();
        test_unlock();
        test_alive_drop();
        test_cfg_reacquire();
        test_timeout();
        test_cfg_load_and_reset();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
